nibble_serial_subtractor: RTL and testbench

- Multi-cycle unsigned/two's-complement subtractor: D = A - B - BIN.
- Processes one 4-bit slice per clock, least significant slice first, with a registered borrow chain between slices.
- Each slice precomputes both borrow-in cases and selects one with the registered borrow, carry-select style.
- This is the subtract counterpart of the team's carry-select adder datapath. It serves as a compact area option for wide subtraction.

---
 rtl/nibble_serial_subtractor_if.sv | 42 ++++
 rtl/nibble_serial_subtractor.sv | 168 ++++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_subtractor_if
//   Request/result bundle for the nibble-serial subtractor.
//
//   Signals (W = 4*NIBBLES):
//     start  requester -> subtractor  operation request
//     a      requester -> subtractor  minuend
//     b      requester -> subtractor  subtrahend
//     bin    requester -> subtractor  borrow-in
//     busy   subtractor -> requester  operation in progress
//     done   subtractor -> requester  one-cycle result-valid pulse
//     d      subtractor -> requester  difference a - b - bin mod 2^W
//     bout   subtractor -> requester  borrow-out
//     ovf    subtractor -> requester  signed overflow
//
//   Modports: master = requester side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface nibble_serial_subtractor_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// nibble_serial_subtractor
//   Multi-cycle subtractor computing D = A - B - BIN over W = 4*NIBBLES bits,
//   one 4-bit slice per clock, least significant slice first. The borrow
//   between slices is registered. Each slice computes both borrow-in
//   candidates and the registered borrow picks one (carry-select style).
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  slave side of nibble_serial_subtractor_if:
//            start/a/b/bin in, busy/done/d/bout/ovf out
//
//   Timing: start accepted at edge k -> done high in the cycle after
//   edge k+NIBBLES. Results hold until the next completion or reset.
// ---------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_subtractor_if.slave  bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4-bit subtract with borrow-in; bit 4 of the result is the borrow-out
  // (the 5-bit difference wraps negative exactly when a borrow is needed).
  function automatic logic [4:0] nib_sub(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       bi);
    return {1'b0, x} - {1'b0, y} - {4'b0000, bi};
  endfunction

  // Control state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;

  // Result registers
  logic [W-1:0]     r_d;
  logic             r_bout;
  logic             r_ovf;

  // Operand and working registers (data only, no reset needed)
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_work;

  logic             w_accept;
  logic [CNT_W+1:0] w_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_cand0;
  logic [4:0]       w_cand1;
  logic [4:0]       w_sel;
  logic [W-1:0]     w_work_next;
  logic             w_ovf_next;

  // start is only honoured outside RUN; reset priority is handled in the FSM.
  assign w_accept = bus.start && (r_state != S_RUN);

  // Bit offset of the current slice: counter * 4.
  assign w_base  = {r_cnt, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];

  // Both borrow-in cases are ready before the registered borrow selects one.
  assign w_cand0 = nib_sub(w_a_nib, w_b_nib, 1'b0);
  assign w_cand1 = nib_sub(w_a_nib, w_b_nib, 1'b1);
  assign w_sel   = r_borrow ? w_cand1 : w_cand0;

  always_comb begin
    w_work_next = r_work;
    w_work_next[w_base +: 4] = w_sel[3:0];
  end

  // Overflow uses the completed difference including the final slice.
  assign w_ovf_next = (r_a[W-1] != r_b[W-1]) && (w_work_next[W-1] != r_a[W-1]);

  // ---- operand capture / slice write-back ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.b;
    end
    if (r_state == S_RUN) begin
      r_work <= w_work_next;
    end
  end

  // ---- control FSM and result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
          end
        end

        S_RUN: begin
          r_borrow <= w_sel[4];
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_SLICE) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_d     <= w_work_next;
            r_bout  <= w_sel[4];
            r_ovf   <= w_ovf_next;
          end
        end

        S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Back-to-back: next operands are latched in the done cycle.
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.d    = r_d;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//   Directed bench for nibble_serial_subtractor with NIBBLES=4.
//   Inputs change 1 time unit after each rising edge; outputs are checked
//   at the same point, so every check sees the state after that edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;

  nibble_serial_subtractor_if #(.NIBBLES(4)) bus ();

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] ed,
                            input logic eb, input logic eo);
    chk({tag, ".d"},    {16'h0, bus.d}, {16'h0, ed});
    chk({tag, ".bout"}, {31'h0, bus.bout}, {31'h0, eb});
    chk({tag, ".ovf"},  {31'h0, bus.ovf},  {31'h0, eo});
  endtask

  // One complete operation with start pulsed for one cycle.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ibin, input logic [15:0] ed, input logic eb,
                        input logic eo);
    bus.a = ia; bus.b = ib; bus.bin = ibin; bus.start = 1'b1;
    step();                                   // accept edge
    bus.start = 1'b0;
    bus.a = ~ia; bus.b = ~ib; bus.bin = ~ibin; // must not affect the result
    chk({tag, ".busy0"}, {31'h0, bus.busy}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, ".busy_run"}, {31'h0, bus.busy}, 32'd1);
      chk({tag, ".done_run"}, {31'h0, bus.done}, 32'd0);
    end
    step();                                   // completion edge
    chk({tag, ".done"}, {31'h0, bus.done}, 32'd1);
    chk({tag, ".busy_done"}, {31'h0, bus.busy}, 32'd0);
    chk_result(tag, ed, eb, eo);
    step();
    chk({tag, ".done_fall"}, {31'h0, bus.done}, 32'd0);
    chk_result({tag, ".hold"}, ed, eb, eo);
  endtask

  logic [15:0] seq_a  [3];
  logic [15:0] seq_b  [3];
  logic        seq_bi [3];
  logic [15:0] seq_d  [3];
  logic        seq_bo [3];
  logic        seq_ov [3];

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0001; bus.bin = 1'b0;

    // Reset held two cycles with start high: reset wins.
    step(); step();
    chk("rst.busy", {31'h0, bus.busy}, 32'd0);
    chk("rst.done", {31'h0, bus.done}, 32'd0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0; bus.start = 1'b0;
    step();
    chk("rst.no_op", {31'h0, bus.busy}, 32'd0);

    // Basic and boundary vectors.
    run_op("basic",  16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0);
    step(); // idle gap; result must still hold
    chk_result("idle_hold", 16'h1233, 1'b0, 1'b0);
    run_op("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("eq_bin", 16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("ovf",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("binf0",  16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0, 1'b0);

    // start pulsed 2 cycles into RUN with other operands: ignored.
    bus.a = 16'h1000; bus.b = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.bin = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ign.busy", {31'h0, bus.busy}, 32'd1);
    step();
    chk("ign.done_early", {31'h0, bus.done}, 32'd0);
    step();
    chk("ign.done", {31'h0, bus.done}, 32'd1);
    chk_result("ign", 16'h0FFF, 1'b0, 1'b0);
    step();
    chk("ign.idle", {31'h0, bus.busy}, 32'd0);

    // start held high: a new operation per DONE cycle, done every 5 cycles.
    seq_a[0] = 16'h0003; seq_b[0] = 16'h0005; seq_bi[0] = 1'b0;
    seq_d[0] = 16'hFFFE; seq_bo[0] = 1'b1; seq_ov[0] = 1'b0;
    seq_a[1] = 16'h7FFF; seq_b[1] = 16'hFFFF; seq_bi[1] = 1'b0;
    seq_d[1] = 16'h8000; seq_bo[1] = 1'b1; seq_ov[1] = 1'b1;
    seq_a[2] = 16'hABCD; seq_b[2] = 16'h1111; seq_bi[2] = 1'b1;
    seq_d[2] = 16'h9ABB; seq_bo[2] = 1'b0; seq_ov[2] = 1'b0;
    bus.a = seq_a[0]; bus.b = seq_b[0]; bus.bin = seq_bi[0]; bus.start = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      if (j < 2) begin
        bus.a = seq_a[j+1]; bus.b = seq_b[j+1]; bus.bin = seq_bi[j+1];
      end else begin
        bus.a = 16'h0; bus.b = 16'h0; bus.bin = 1'b0;
      end
      chk("b2b.busy", {31'h0, bus.busy}, 32'd1);
      step(); step(); step();
      chk("b2b.done_early", {31'h0, bus.done}, 32'd0);
      if (j == 2) bus.start = 1'b0;
      step();
      chk("b2b.done", {31'h0, bus.done}, 32'd1);
      chk_result("b2b", seq_d[j], seq_bo[j], seq_ov[j]);
      step();
      chk("b2b.done_fall", {31'h0, bus.done}, 32'd0);
    end
    chk("b2b.idle", {31'h0, bus.busy}, 32'd0);

    // Reset in the 2nd RUN cycle aborts the operation.
    bus.a = 16'h1234; bus.b = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy", {31'h0, bus.busy}, 32'd0);
    chk("abort.done", {31'h0, bus.done}, 32'd0);
    chk_result("abort", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort.no_done", {31'h0, bus.done}, 32'd0);
    end
    run_op("after_abort", 16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
